// File: rtl/cordic_scheduler_if.sv
// Request, engine and response signals of the CORDIC scheduler.
// The master side is the environment (requesters, engine, consumer); the slave side is the scheduler.
interface cordic_scheduler_if;
    logic       req0_valid;
    logic [5:0] req0_angle;
    logic       req0_ready;
    logic       req1_valid;
    logic [5:0] req1_angle;
    logic       req1_ready;
    logic       eng_start;
    logic [5:0] eng_angle;
    logic       eng_done;
    logic [5:0] eng_x;
    logic [5:0] eng_y;
    logic       rsp_valid;
    logic       rsp_ready;
    logic       rsp_id;
    logic [5:0] rsp_x;
    logic [5:0] rsp_y;
    logic       rsp_err;
    logic       busy;
    logic [1:0] dbg_state;

    modport master (
        output req0_valid, req0_angle, req1_valid, req1_angle,
        output eng_done, eng_x, eng_y, rsp_ready,
        input  req0_ready, req1_ready, eng_start, eng_angle,
        input  rsp_valid, rsp_id, rsp_x, rsp_y, rsp_err, busy, dbg_state
    );

    modport slave (
        input  req0_valid, req0_angle, req1_valid, req1_angle,
        input  eng_done, eng_x, eng_y, rsp_ready,
        output req0_ready, req1_ready, eng_start, eng_angle,
        output rsp_valid, rsp_id, rsp_x, rsp_y, rsp_err, busy, dbg_state
    );
endinterface

// File: rtl/cordic_scheduler.sv
// Two-requester arbiter in front of a single CORDIC engine: grants one angle at a time,
// starts the engine, waits with a timeout and returns the result (or an error) to the consumer.
module cordic_scheduler #(
    parameter int unsigned TIMEOUT = 15
) (
    input logic               clk,
    input logic               reset,
    cordic_scheduler_if.slave bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic [5:0] BAD_ANGLE   = 6'b100000;
    localparam logic [3:0] TIMEOUT_CNT = TIMEOUT[3:0];

    logic [1:0] state_q, state_d;
    logic       prio_q, prio_d;
    logic [5:0] angle_q, angle_d;
    logic [3:0] cnt_q, cnt_d;
    logic       id_q, id_d;
    logic       err_q, err_d;
    logic [5:0] x_q, x_d;
    logic [5:0] y_q, y_d;

    logic       grant_any;
    logic       grant_id;
    logic [5:0] grant_angle;

    // Arbitration: a lone requester wins outright, a tie goes to prio_q.
    always_comb begin
        grant_any = bus.req0_valid | bus.req1_valid;
        if (bus.req0_valid && bus.req1_valid) begin
            grant_id = prio_q;
        end else begin
            grant_id = bus.req1_valid;
        end
        grant_angle = grant_id ? bus.req1_angle : bus.req0_angle;
    end

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        angle_d = angle_q;
        cnt_d   = cnt_q;
        id_d    = id_q;
        err_d   = err_q;
        x_d     = x_q;
        y_d     = y_q;
        case (state_q)
            S_IDLE: begin
                if (grant_any) begin
                    id_d    = grant_id;
                    angle_d = grant_angle;
                    cnt_d   = 4'd0;
                    if (grant_angle == BAD_ANGLE) begin
                        err_d   = 1'b1;
                        x_d     = 6'd0;
                        y_d     = 6'd0;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                cnt_d   = 4'd0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A completion in the same cycle as the timeout still counts as success.
                if (bus.eng_done) begin
                    x_d     = bus.eng_x;
                    y_d     = bus.eng_y;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_d == TIMEOUT_CNT) begin
                        x_d     = 6'd0;
                        y_d     = 6'd0;
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    prio_d  = ~id_q;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            prio_q  <= 1'b0;
            angle_q <= 6'd0;
            cnt_q   <= 4'd0;
            id_q    <= 1'b0;
            err_q   <= 1'b0;
            x_q     <= 6'd0;
            y_q     <= 6'd0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            angle_q <= angle_d;
            cnt_q   <= cnt_d;
            id_q    <= id_d;
            err_q   <= err_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    // Handshakes: a requester transfers on a rising edge where its valid and ready are both high;
    // ready is a one-cycle grant in IDLE only. The response transfers where rsp_valid && rsp_ready.
    always_comb begin
        bus.req0_ready = ~reset & (state_q == S_IDLE) & grant_any & ~grant_id;
        bus.req1_ready = ~reset & (state_q == S_IDLE) & grant_any & grant_id;
        bus.eng_start  = (state_q == S_ISSUE);
        bus.eng_angle  = ((state_q == S_ISSUE) || (state_q == S_WAIT)) ? angle_q : 6'd0;
        bus.rsp_valid  = (state_q == S_RESP);
        bus.rsp_id     = id_q;
        bus.rsp_x      = x_q;
        bus.rsp_y      = y_q;
        bus.rsp_err    = err_q;
        bus.busy       = (state_q != S_IDLE);
        bus.dbg_state  = state_q;
    end

endmodule

// File: tb/tb_cordic_scheduler.sv
// Directed scoreboard bench for cordic_scheduler with a behavioural engine model.
module tb_cordic_scheduler;

  logic clk;
  logic reset;
  cordic_scheduler_if bus();

  cordic_scheduler #(.TIMEOUT(15)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  localparam int TMO = 15;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [13:0] exp_q[$];

  int         eng_delay = 0;
  logic [5:0] eng_x_cfg = '0;
  logic [5:0] eng_y_cfg = '0;
  bit         inject_done = 0;
  int         eng_cnt = 0;

  int         n_starts = 0;
  int         grant_cyc = 0;
  int         start_cyc = 0;
  int         rspv_cyc = 0;
  logic [5:0] grant_angle = '0;

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_idle(input string name);
    check({name, "_outs"},
          {7'd0, bus.req0_ready, bus.req1_ready, bus.eng_start, bus.eng_angle, bus.rsp_valid,
           bus.rsp_id, bus.rsp_x, bus.rsp_y, bus.rsp_err, bus.busy}, 32'd0);
    check({name, "_state"}, {30'd0, bus.dbg_state}, 32'd0);
  endtask

  // engine model: done pulses eng_delay cycles after start; eng_delay 0 means never
  initial begin
    bus.eng_done = 1'b0;
    bus.eng_x = '0;
    bus.eng_y = '0;
    forever begin
      @(negedge clk);
      bus.eng_done = 1'b0;
      if (inject_done) begin
        bus.eng_done = 1'b1;
        bus.eng_x = 6'h2A;
        bus.eng_y = 6'h15;
        inject_done = 0;
      end
      if (eng_cnt > 0) begin
        eng_cnt--;
        if (eng_cnt == 0) begin
          bus.eng_done = 1'b1;
          bus.eng_x = eng_x_cfg;
          bus.eng_y = eng_y_cfg;
        end
      end
      if (bus.eng_start) eng_cnt = eng_delay;
      if (reset) eng_cnt = 0;
    end
  end

  // monitor / scoreboard
  initial begin
    logic        prev_r0, prev_r1, prev_start, prev_valid, held, in_eng;
    logic [13:0] prev_rsp, cur_rsp, e;
    prev_r0 = 0; prev_r1 = 0; prev_start = 0; prev_valid = 0; held = 0; in_eng = 0;
    prev_rsp = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_r0 = 0; prev_r1 = 0; prev_start = 0; prev_valid = 0; held = 0; in_eng = 0;
      end else begin
        if (bus.req0_ready || bus.req1_ready) begin
          check("ready_onehot", {31'd0, bus.req0_ready & bus.req1_ready}, 32'd0);
          grant_cyc = cyc;
          grant_angle = bus.req1_ready ? bus.req1_angle : bus.req0_angle;
        end
        if (bus.req0_ready) check("ready0_single", {31'd0, prev_r0}, 32'd0);
        if (bus.req1_ready) check("ready1_single", {31'd0, prev_r1}, 32'd0);
        if (bus.rsp_valid) in_eng = 0;
        if (bus.eng_start) begin
          n_starts++;
          start_cyc = cyc;
          check("start_single", {31'd0, prev_start}, 32'd0);
          in_eng = 1;
        end
        if (in_eng) check("eng_angle", {26'd0, bus.eng_angle}, {26'd0, grant_angle});
        cur_rsp = {bus.rsp_id, bus.rsp_err, bus.rsp_x, bus.rsp_y};
        if (bus.rsp_valid) begin
          if (!prev_valid) rspv_cyc = cyc;
          if (held) check("rsp_stable", {18'd0, cur_rsp}, {18'd0, prev_rsp});
          if (bus.rsp_ready) begin
            if (exp_q.size() == 0) begin
              check("rsp_unexpected", 32'd1, 32'd0);
            end else begin
              e = exp_q.pop_front();
              check("rsp", {18'd0, cur_rsp}, {18'd0, e});
            end
            held = 0;
          end else begin
            held = 1;
            prev_rsp = cur_rsp;
          end
        end else begin
          held = 0;
        end
        prev_r0 = bus.req0_ready;
        prev_r1 = bus.req1_ready;
        prev_start = bus.eng_start;
        prev_valid = bus.rsp_valid;
      end
    end
  end

  // driver tasks
  function automatic logic [13:0] model(input bit id, input logic [5:0] ang, input int dly,
                                        input logic [5:0] x, input logic [5:0] y);
    if (ang == 6'b100000 || dly == 0 || dly > TMO) return {id, 1'b1, 12'd0};
    return {id, 1'b0, x, y};
  endfunction

  task automatic wait_grant(input bit id, input string name);
    bit got = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (id ? bus.req1_ready : bus.req0_ready) begin
        got = 1;
        break;
      end
    end
    check({name, "_grant"}, {31'd0, got}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    check({name, "_drain"}, exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  task automatic do_req(input bit id, input logic [5:0] ang, input int dly,
                        input logic [5:0] x, input logic [5:0] y, input string name);
    @(posedge clk);
    #1;
    eng_delay = dly;
    eng_x_cfg = x;
    eng_y_cfg = y;
    exp_q.push_back(model(id, ang, dly, x, y));
    if (id) begin
      bus.req1_valid = 1'b1;
      bus.req1_angle = ang;
    end else begin
      bus.req0_valid = 1'b1;
      bus.req0_angle = ang;
    end
    wait_grant(id, name);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    drain(name);
  endtask

  initial begin
    int starts_before;
    int k;
    bit seen;
    reset = 1'b1;
    bus.req0_valid = 1'b1;
    bus.req0_angle = 6'd9;
    bus.req1_valid = 1'b0;
    bus.req1_angle = '0;
    bus.rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    @(posedge clk);
    #1;
    bus.req0_valid = 1'b0;
    reset = 1'b0;

    // single request, done 6 cycles after start
    do_req(0, 6'd16, 6, 6'd13, 6'd13, "basic45");
    check("basic45_lat", rspv_cyc - start_cyc, 32'd7);

    // out-of-range angle skips the engine
    starts_before = n_starts;
    do_req(1, 6'b100000, 3, 6'd1, 6'd1, "bad_angle");
    check("bad_angle_nostart", n_starts - starts_before, 32'd0);
    check("bad_angle_lat", rspv_cyc - grant_cyc, 32'd1);

    // engine never completes
    do_req(0, 6'd5, 0, 6'd0, 6'd0, "timeout");
    check("timeout_lat", rspv_cyc - start_cyc, 32'd16);

    // done on the last allowed WAIT cycle wins over the timeout
    do_req(1, 6'h21, 15, 6'h3F, 6'h01, "done_at_limit");
    check("done_at_limit_lat", rspv_cyc - start_cyc, 32'd16);

    // done one cycle too late: timeout, late done ignored in RESP
    do_req(0, 6'h1F, 16, 6'h11, 6'h22, "done_late");

    // minimum turnaround
    do_req(1, 6'h30, 1, 6'd2, 6'd3, "fast");
    check("fast_lat", rspv_cyc - start_cyc, 32'd2);

    // consumer stalls for several RESP cycles while req0 keeps requesting
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    eng_delay = 2;
    eng_x_cfg = 6'd9;
    eng_y_cfg = 6'd10;
    exp_q.push_back(model(0, 6'd8, 2, 6'd9, 6'd10));
    bus.req0_valid = 1'b1;
    bus.req0_angle = 6'd8;
    wait_grant(0, "stall");
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        seen = 1;
        break;
      end
    end
    check("stall_rsp_seen", {31'd0, seen}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_no_grant", {31'd0, bus.req0_ready}, 32'd0);
    end
    exp_q.push_back(model(0, 6'd8, 2, 6'd9, 6'd10));
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("regrant_after_hs", {31'd0, bus.req0_ready}, 32'd1);
    @(posedge clk);
    #1;
    bus.req0_valid = 1'b0;
    drain("stall");

    // both requesters valid continuously from reset: grants alternate
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    eng_delay = 1;
    eng_x_cfg = 6'd5;
    eng_y_cfg = 6'd7;
    for (int i = 0; i < 4; i++) exp_q.push_back(model(i[0], 6'd3, 1, 6'd5, 6'd7));
    bus.req0_valid = 1'b1;
    bus.req0_angle = 6'd3;
    bus.req1_valid = 1'b1;
    bus.req1_angle = 6'd4;
    k = 0;
    for (int i = 0; i < 300 && k < 4; i++) begin
      @(negedge clk);
      if (bus.req0_ready || bus.req1_ready) begin
        check("alt_grant", {31'd0, bus.req1_ready}, {31'd0, k[0]});
        k++;
      end
    end
    check("alt_count", k, 32'd4);
    @(posedge clk);
    #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    drain("alternate");

    // reset in the middle of WAIT, then a stray done
    @(posedge clk);
    #1;
    eng_delay = 0;
    bus.req0_valid = 1'b1;
    bus.req0_angle = 6'd12;
    wait_grant(0, "mid_wait");
    bus.req0_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("mid_wait_busy", {31'd0, bus.busy}, 32'd1);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    inject_done = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_idle("post_reset");
    end
    check("post_reset_queue", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
